regfile_ff_read: RTL

Flip-flop based multi-port register file: the read side and storage that consume the one-hot write-enable decode of the write ports. It holds 31 (or 32) words of DATA_WIDTH bits, accepts up to NR_WRITE_PORTS writes per cycle, and serves NR_READ_PORTS independent combinational reads. It sits in the core's decode/issue stage, between the operand-address fields and the ALU operand muxes.

---
 rtl/regfile_ff_read.sv | 68 ++++++
 1 files changed

// File: rtl/regfile_ff_read.sv
// Flip-flop register file: 32 words, multiple combinational read ports, and
// multiple write ports where the highest-indexed port wins when ports collide.
module regfile_ff_read #(
  parameter int DATA_WIDTH     = 32,
  parameter int NR_READ_PORTS  = 2,
  parameter int NR_WRITE_PORTS = 2,
  parameter bit ZERO_REG_ZERO  = 1'b0,
  parameter bit WRITE_BYPASS   = 1'b0
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic [NR_READ_PORTS-1:0][4:0]              raddr_i,
  output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]   rdata_o,
  input  logic [NR_WRITE_PORTS-1:0][4:0]             waddr_i,
  input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
  input  logic [NR_WRITE_PORTS-1:0]                  we_i
);

  logic [NR_WRITE_PORTS-1:0][31:0] wen;
  logic [DATA_WIDTH-1:0]           mem [32];

  // One-hot write decode; word 0 can never be enabled when it is hardwired.
  always_comb begin
    wen = '0;
    for (int p = 0; p < NR_WRITE_PORTS; p++) begin
      for (int w = 0; w < 32; w++) begin
        wen[p][w] = we_i[p] && (waddr_i[p] == w[4:0]) && !(ZERO_REG_ZERO && (w == 0));
      end
    end
  end

  for (genvar w = 0; w < 32; w++) begin : g_word
    if (ZERO_REG_ZERO && (w == 0)) begin : g_zero
      assign mem[w] = '0;
    end else begin : g_store
      logic [DATA_WIDTH-1:0] word_q, word_d;

      // Ascending port scan: the last enabled match is the highest port.
      always_comb begin
        word_d = word_q;
        for (int p = 0; p < NR_WRITE_PORTS; p++) begin
          if (wen[p][w]) word_d = wdata_i[p];
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) word_q <= '0;
        else         word_q <= word_d;
      end

      assign mem[w] = word_q;
    end
  end

  // Bypass is held off in reset: a write issued during reset never commits.
  always_comb begin
    rdata_o = '0;
    for (int r = 0; r < NR_READ_PORTS; r++) begin
      rdata_o[r] = mem[raddr_i[r]];
      if (WRITE_BYPASS && rst_ni) begin
        for (int p = 0; p < NR_WRITE_PORTS; p++) begin
          if (wen[p][raddr_i[r]]) rdata_o[r] = wdata_i[p];
        end
      end
    end
  end

endmodule
